bus: RTL and testbench

BUS -- requirements
Module: bus

---
 rtl/bus_if.sv | 38 +++
 rtl/bus.sv | 87 ++++++++
 tb/tb_bus.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_if.sv
// ============================================================================
//  Module      : bus_if
//  Description : Handshake bundle between the upstream producer, the tag bus
//                and the attached masters (PEs). The slave modport is the bus
//                itself; the master modport is the environment that drives
//                upstream data and per-master ready.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bus_if #(
   parameter int MASTER_NUMS = 14,
   parameter int ID_LEN      = 4,
   parameter int VALUE_LEN   = 8
);
   // {enable, tag, value} from upstream
   logic [VALUE_LEN+ID_LEN:0] enable_tag_value;
   logic                      ready;
   // per-master ready and {enable, value}
   logic                      master_ready       [MASTER_NUMS];
   logic [VALUE_LEN:0]        master_enable_data [MASTER_NUMS];

   modport master (
      output enable_tag_value,
      output master_ready,
      input  ready,
      input  master_enable_data
   );

   modport slave (
      input  enable_tag_value,
      input  master_ready,
      output ready,
      output master_enable_data
   );
endinterface

`default_nettype wire

// File: rtl/bus.sv
// ============================================================================
//  Module      : bus
//  Description : Tag-matched multicast bus. Each attached master owns an ID
//                register; the IDs form a serial scan chain loaded through
//                set_id/id_scan_in. An upstream {enable, tag, value} word is
//                broadcast to every master whose ID equals the tag, and is
//                accepted only when all matching masters are ready.
//  Config      : BUS_NOMATCH_DROP_EN - when defined, a word whose tag matches
//                no master is accepted (dropped) instead of stalling upstream.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus #(
   parameter int MASTER_NUMS = 14,
   parameter int ID_LEN      = 4,
   parameter int VALUE_LEN   = 8
) (
   input  wire                clk,
   input  wire                rst,
   input  wire                set_id,
   input  wire   [ID_LEN-1:0] id_scan_in,
   output logic  [ID_LEN-1:0] id_scan_out,
   bus_if.slave               bif
);

   localparam logic [ID_LEN-1:0] c_ID_RESET = '1;

`ifdef BUS_NOMATCH_DROP_EN
   localparam logic c_NOMATCH_READY = 1'b1;
`else
   localparam logic c_NOMATCH_READY = 1'b0;
`endif

   logic [ID_LEN-1:0]    r_id [MASTER_NUMS];

   logic                 w_enable;
   logic [ID_LEN-1:0]    w_tag;
   logic [VALUE_LEN-1:0] w_value;
   logic [MASTER_NUMS-1:0] w_match;
   logic [MASTER_NUMS-1:0] w_blocked;
   logic                 w_ready;

   assign w_enable = bif.enable_tag_value[VALUE_LEN+ID_LEN];
   assign w_tag    = bif.enable_tag_value[VALUE_LEN +: ID_LEN];
   assign w_value  = bif.enable_tag_value[VALUE_LEN-1:0];

   // ID scan chain: reset to all-ones (reset wins over shifting), shift on set_id
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < MASTER_NUMS; k++) begin
            r_id[k] <= c_ID_RESET;
         end
      end else if (set_id) begin
         r_id[0] <= id_scan_in;
         for (int k = 1; k < MASTER_NUMS; k++) begin
            r_id[k] <= r_id[k-1];
         end
      end
   end

   assign id_scan_out = r_id[MASTER_NUMS-1];

   // Per-master tag compare and output; value is broadcast to every master
   for (genvar k = 0; k < MASTER_NUMS; k++) begin : g_master
      assign w_match[k]   = (r_id[k] == w_tag);
      assign w_blocked[k] = w_match[k] & ~bif.master_ready[k];
      assign bif.master_enable_data[k] = {w_enable & w_match[k] & ~set_id, w_value};
   end

   // Upstream ready: all-or-nothing across matching masters; scanning blocks all
   always_comb begin
      w_ready = 1'b0;
      if (w_enable && !set_id) begin
         if (|w_match) begin
            w_ready = ~|w_blocked;
         end else begin
            w_ready = c_NOMATCH_READY;
         end
      end
   end

   assign bif.ready = w_ready;

endmodule

`default_nettype wire

// File: tb/tb_bus.sv
// ============================================================================
//  Module      : tb_bus
//  Description : Self-checking bench for bus: hand-computed vector table,
//                directed scan/multicast sequences and randomized traffic
//                against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus;

   localparam int MN = 14;
   localparam int IL = 4;
   localparam int VL = 8;

`ifdef BUS_NOMATCH_DROP_EN
   localparam bit c_DROP = 1'b1;
`else
   localparam bit c_DROP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          set_id;
   logic [IL-1:0] id_scan_in;
   logic [IL-1:0] id_scan_out;

   // driven stimulus mirrors
   logic          en;
   logic [IL-1:0] tag;
   logic [VL-1:0] val;
   logic [MN-1:0] mrdy;

   int checks = 0;
   int errors = 0;

   // reference model: the ID chain as a queue, element 0 is id[0]
   logic [IL-1:0] m_id [$];

   bus_if #(.MASTER_NUMS(MN), .ID_LEN(IL), .VALUE_LEN(VL)) bif ();

   bus #(.MASTER_NUMS(MN), .ID_LEN(IL), .VALUE_LEN(VL)) dut (
      .clk         (clk),
      .rst         (rst),
      .set_id      (set_id),
      .id_scan_in  (id_scan_in),
      .id_scan_out (id_scan_out),
      .bif         (bif)
   );

   always #5 clk = ~clk;

   always_comb begin
      bif.enable_tag_value = {en, tag, val};
      for (int k = 0; k < MN; k++) bif.master_ready[k] = mrdy[k];
   end

   typedef struct {
      logic          en;
      logic [IL-1:0] tag;
      logic [VL-1:0] val;
      logic [MN-1:0] mrdy;
      logic          exp_ready;
      logic [MN-1:0] exp_mask;
   } vec_t;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [MN-1:0] dut_mask();
      logic [MN-1:0] m;
      for (int k = 0; k < MN; k++) m[k] = bif.master_enable_data[k][VL];
      return m;
   endfunction

   task automatic check_values(input string name);
      for (int k = 0; k < MN; k++) cmp(name, 32'(bif.master_enable_data[k][VL-1:0]), 32'(val));
   endtask

   // Expectations straight from the bus rules, using the model chain
   task automatic check_model(input string name);
      logic [MN-1:0] e_mask;
      int            n_match;
      int            n_busy;
      logic          e_ready;
      e_mask  = '0;
      n_match = 0;
      n_busy  = 0;
      for (int k = 0; k < MN; k++) begin
         if (m_id[k] == tag) begin
            n_match++;
            if (!mrdy[k]) n_busy++;
            if (en && !set_id) e_mask[k] = 1'b1;
         end
      end
      if (!en || set_id)     e_ready = 1'b0;
      else if (n_match == 0) e_ready = c_DROP;
      else                   e_ready = (n_busy == 0);
      cmp({name, ".scan_out"}, 32'(id_scan_out), 32'(m_id[MN-1]));
      cmp({name, ".ready"},    32'(bif.ready),   32'(e_ready));
      cmp({name, ".mask"},     32'(dut_mask()),  32'(e_mask));
      check_values({name, ".value"});
   endtask

   // One rising edge; the model takes the same inputs the DUT samples
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k < MN; k++) m_id[k] = '1;
      end else if (set_id) begin
         m_id.push_front(id_scan_in);
         void'(m_id.pop_back());
      end
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t vt [8];

      for (int k = 0; k < MN; k++) m_id.push_back('0);
      rst = 1'b1; set_id = 1'b0; id_scan_in = '0;
      en = 1'b0; tag = '0; val = '0; mrdy = '1;
      @(negedge clk);
      tick();
      rst = 1'b0;
      #1;

      // reset state: all IDs F, so tag F hits every master
      cmp("reset.scan_out", 32'(id_scan_out), 32'hF);
      en = 1'b1; tag = 4'hF; val = 8'h5A; #1;
      cmp("reset.ready_all", 32'(bif.ready), 32'h1);
      cmp("reset.mask_all",  32'(dut_mask()), 32'h3FFF);
      check_model("reset");

      // load 6..0,6..0 while a matching transfer is offered (must be blocked)
      set_id = 1'b1; tag = 4'h6;
      for (int i = 0; i < 2 * 7; i++) begin
         id_scan_in = IL'(6 - (i % 7));
         #1;
         cmp("scan.ready_blocked", 32'(bif.ready), 32'h0);
         cmp("scan.mask_blocked",  32'(dut_mask()), 32'h0);
         tick();
      end
      set_id = 1'b0; #1;
      cmp("scan.scan_out_after14", 32'(id_scan_out), 32'h6);
      check_model("scan.loaded");

      // table of hand-computed vectors with ids[k] = k % 7
      vt[0] = '{1'b1, 4'h2, 8'h02, 14'h3FFF, 1'b1,   14'h0204};
      vt[1] = '{1'b1, 4'h2, 8'h02, 14'h3DFF, 1'b0,   14'h0204};
      vt[2] = '{1'b1, 4'h0, 8'h11, 14'h3FFF, 1'b1,   14'h0081};
      vt[3] = '{1'b1, 4'h6, 8'hC3, 14'h3FFF, 1'b1,   14'h2040};
      vt[4] = '{1'b1, 4'hF, 8'h77, 14'h3FFF, c_DROP, 14'h0000};
      vt[5] = '{1'b0, 4'h2, 8'h02, 14'h3FFF, 1'b0,   14'h0000};
      vt[6] = '{1'b1, 4'h3, 8'h33, 14'h0408, 1'b1,   14'h0408};
      vt[7] = '{1'b1, 4'h3, 8'h33, 14'h0008, 1'b0,   14'h0408};
      for (int i = 0; i < 8; i++) begin
         en = vt[i].en; tag = vt[i].tag; val = vt[i].val; mrdy = vt[i].mrdy;
         #2;
         cmp($sformatf("vec%0d.ready", i), 32'(bif.ready),  32'(vt[i].exp_ready));
         cmp($sformatf("vec%0d.mask", i),  32'(dut_mask()), 32'(vt[i].exp_mask));
         check_values($sformatf("vec%0d.value", i));
      end

      // master 9 releases ready in the same cycle as the stalled transfer
      en = 1'b1; tag = 4'h2; val = 8'h02; mrdy = 14'h3DFF; #1;
      cmp("stall9.ready", 32'(bif.ready), 32'h0);
      mrdy[9] = 1'b1; #1;
      cmp("release9.ready", 32'(bif.ready), 32'h1);

      // tags 0..6 with 0x00..0x06, then 0xFF..0xF9, one cycle each
      for (int i = 0; i < 14; i++) begin
         tag = IL'(i % 7);
         val = (i < 7) ? VL'(i) : VL'(8'hFF - (i - 7));
         #1;
         cmp($sformatf("seq%0d.ready", i), 32'(bif.ready), 32'h1);
         cmp($sformatf("seq%0d.mask", i), 32'(dut_mask()),
             32'((14'h1 << (i % 7)) | (14'h1 << ((i % 7) + 7))));
         check_values($sformatf("seq%0d.value", i));
         tick();
      end

      // reset in the middle of a scan discards the partial shift
      set_id = 1'b1;
      for (int i = 0; i < 3; i++) begin
         id_scan_in = IL'(i + 8);
         tick();
      end
      rst = 1'b1; id_scan_in = 4'h3;
      tick();
      rst = 1'b0; set_id = 1'b0; tag = 4'hF; mrdy = '1; #1;
      cmp("midscan_rst.scan_out", 32'(id_scan_out), 32'hF);
      cmp("midscan_rst.mask", 32'(dut_mask()), 32'h3FFF);
      check_model("midscan_rst");

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         rst        = ($urandom_range(0, 39) == 0);
         set_id     = ($urandom_range(0, 3) == 0);
         id_scan_in = IL'($urandom_range(0, 7));
         en         = ($urandom_range(0, 4) != 0);
         tag        = IL'($urandom_range(0, 8));
         val        = VL'($urandom);
         for (int k = 0; k < MN; k++) mrdy[k] = ($urandom_range(0, 9) != 0);
         #1;
         check_model("rand");
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
